// File: rtl/handshake_tx_arbiter.sv
// Round-robin arbiter driving the transmit side of a four-phase CDC handshake.
// Define HS_ARB_TIMEOUT_EN to compile in the per-phase ack timeout (err_o).
module handshake_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DW-1:0]      req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       hs_req_o,
    output logic [DW-1:0]              hs_data_o,
    input  logic                       hs_ack_i,
    output logic                       err_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic CFG_OK = (NUM_REQ >= 2) && (NUM_REQ <= 8) &&
                              (TIMEOUT_CYCLES >= 1);

    typedef enum logic [1:0] {IDLE, ASSERT, DEASSERT} state_e;

    state_e               state_q, state_d;
    logic                 ack_s1_q, ack_s_q;
    logic                 hs_req_q, hs_req_d;
    logic [DW-1:0]        data_q, data_d;
    logic [IW-1:0]        gid_q, gid_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 win_vld;
    logic [IW-1:0]        win_idx;
    logic                 accept;
    int                   rr_j;

`ifdef HS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_seen_q, err_seen_d;
    logic                 tmo;
    assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

    // Search starts at ptr_q, which holds the index after the last winner.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        rr_j    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_j = int'(ptr_q) + k;
            if (rr_j >= NUM_REQ) rr_j = rr_j - NUM_REQ;
            if (!win_vld && req_valid_i[IW'(rr_j)]) begin
                win_vld = 1'b1;
                win_idx = IW'(rr_j);
            end
        end
    end

    assign accept = CFG_OK && (state_q == IDLE) && !ack_s_q && win_vld;
    assign req_ready_o = accept ? (NUM_REQ'(1) << win_idx) : '0;

    always_comb begin
        state_d  = state_q;
        hs_req_d = hs_req_q;
        data_d   = data_q;
        gid_d    = gid_q;
        ptr_d    = ptr_q;
        done_d   = '0;
        err_d    = 1'b0;
`ifdef HS_ARB_TIMEOUT_EN
        cnt_d      = cnt_q + CW'(1);
        err_seen_d = err_seen_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d   = req_data_i[int'(win_idx)*DW +: DW];
                    gid_d    = win_idx;
                    hs_req_d = 1'b1;
                    state_d  = ASSERT;
                    ptr_d    = (win_idx == IW'(NUM_REQ - 1)) ?
                               '0 : win_idx + 1'b1;
`ifdef HS_ARB_TIMEOUT_EN
                    err_seen_d = 1'b0;
`endif
                end
            end
            ASSERT: begin
                if (ack_s_q) begin
                    hs_req_d = 1'b0;
                    state_d  = DEASSERT;
                end
`ifdef HS_ARB_TIMEOUT_EN
                else if (tmo) begin
                    hs_req_d   = 1'b0;
                    err_d      = 1'b1;
                    err_seen_d = 1'b1;
                    state_d    = DEASSERT;
                end
`endif
            end
            DEASSERT: begin
`ifdef HS_ARB_TIMEOUT_EN
                // After an ASSERT timeout, sit out a full window so a late ack settles.
                if (!ack_s_q && !err_seen_q) begin
                    done_d  = NUM_REQ'(1) << gid_q;
                    state_d = IDLE;
                end else if (tmo) begin
                    err_d      = !err_seen_q;
                    err_seen_d = 1'b1;
                    state_d    = IDLE;
                end
`else
                if (!ack_s_q) begin
                    done_d  = NUM_REQ'(1) << gid_q;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
`ifdef HS_ARB_TIMEOUT_EN
        if (state_d != state_q || state_q == IDLE) cnt_d = '0;
`endif
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ack_s1_q <= 1'b0;
            ack_s_q  <= 1'b0;
            hs_req_q <= 1'b0;
            data_q   <= '0;
            gid_q    <= '0;
            ptr_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_s1_q <= hs_ack_i;
            ack_s_q  <= ack_s1_q;
            hs_req_q <= hs_req_d;
            data_q   <= data_d;
            gid_q    <= gid_d;
            ptr_q    <= ptr_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

`ifdef HS_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            err_seen_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            err_seen_q <= err_seen_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign done_o     = done_q;
    assign busy_o     = busy_q;
    assign grant_id_o = gid_q;
    assign hs_req_o   = hs_req_q;
    assign hs_data_o  = data_q;

endmodule

// File: tb/tb_handshake_tx_arbiter.sv
// Self-checking bench for handshake_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=15).
module tb_handshake_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_ready_o;
    logic [N-1:0]    done_o;
    logic            busy_o;
    logic [1:0]      grant_id_o;
    logic            hs_req_o;
    logic [DW-1:0]   hs_data_o;
    logic            hs_ack_i;
    logic            err_o;

    handshake_tx_arbiter #(.NUM_REQ(N), .DW(DW), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o), .done_o(done_o), .busy_o(busy_o),
        .grant_id_o(grant_id_o), .hs_req_o(hs_req_o), .hs_data_o(hs_data_o),
        .hs_ack_i(hs_ack_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vm;
        int         id;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] data;
    } sb_t;

    sb_t  sb_q[$];
    vec_t tbl[10];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest accepted transfer.
    always @(negedge clk) begin
        if (rst_n && done_o != '0) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", 64'(done_o), 64'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("sb_done", 64'(done_o), 64'(4'b1 << e.id));
                chk("sb_data", 64'(hs_data_o), 64'(e.data));
            end
        end
    end

    task automatic set_data(input logic [31:0] base);
        for (int i = 0; i < N; i++) req_data_i[i*DW +: DW] = base + 32'(i);
    endtask

    task automatic do_xfer(input logic [3:0] vm, input int exp_id,
                           input int dly, input logic [31:0] base);
        int n;
        logic [31:0] w;
        @(posedge clk); #1;
        set_data(base);
        req_valid_i = vm;
        n = 0;
        @(negedge clk);
        while (req_ready_o == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_ready", 64'(req_ready_o), 64'(4'b1 << exp_id));
        if (req_ready_o == '0) begin
            req_valid_i = '0;
            return;
        end
        w = base + 32'(exp_id);
        sb_q.push_back('{exp_id, w});
        @(posedge clk); #1;
        req_valid_i[exp_id] = 1'b0;
        @(negedge clk);
        chk("assert_req", 64'(hs_req_o), 64'd1);
        chk("assert_data", 64'(hs_data_o), 64'(w));
        chk("assert_gid", 64'(grant_id_o), 64'(exp_id));
        chk("assert_busy", 64'(busy_o), 64'd1);
        chk("assert_noready", 64'(req_ready_o), 64'd0);
        repeat (dly) @(posedge clk);
        #1 hs_ack_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("req_hold_a2", 64'(hs_req_o), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("req_drop_a3", 64'(hs_req_o), 64'd0);
        @(posedge clk); #1;
        hs_ack_i    = 1'b0;
        req_valid_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("done_early", 64'(done_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("done_f3", 64'(done_o), 64'(4'b1 << exp_id));
        chk("idle_busy", 64'(busy_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("done_once", 64'(done_o), 64'd0);
        chk("data_kept", 64'(hs_data_o), 64'(w));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b1111, 1};
        tbl[1] = '{4'b1111, 2};
        tbl[2] = '{4'b1111, 3};
        tbl[3] = '{4'b1111, 0};
        tbl[4] = '{4'b1111, 1};
        tbl[5] = '{4'b0101, 2};
        tbl[6] = '{4'b0011, 0};
        tbl[7] = '{4'b1000, 3};
        tbl[8] = '{4'b0110, 1};
        tbl[9] = '{4'b1001, 3};

        rst_n       = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        hs_ack_i    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", 64'(hs_req_o), 64'd0);
        chk("rst_data", 64'(hs_data_o), 64'd0);
        chk("rst_gid", 64'(grant_id_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        do_xfer(4'b0001, 0, 5, 32'hDEADBEEF);

        for (int i = 0; i < 10; i++)
            do_xfer(tbl[i].vm, tbl[i].id, 1 + (i % 3), 32'h1000_0000 * (i + 1));

        // Stale ack held in IDLE blocks grants until ack_s falls.
        @(posedge clk); #1 hs_ack_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 req_valid_i = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stale_noready", 64'(req_ready_o), 64'd0);
        end
        @(posedge clk); #1 hs_ack_i = 1'b0;
        @(negedge clk);
        chk("stale_f0", 64'(req_ready_o), 64'd0);
        @(negedge clk);
        chk("stale_f1", 64'(req_ready_o), 64'd0);
        @(negedge clk);
        chk("stale_f2", 64'(req_ready_o), 64'b0010);
        req_valid_i = '0;
        @(negedge clk);
        chk("withdraw_busy", 64'(busy_o), 64'd0);
        chk("withdraw_req", 64'(hs_req_o), 64'd0);
        do_xfer(4'b0010, 1, 2, 32'hC0DE_0000);

        // Reset in ASSERT.
        @(posedge clk); #1;
        set_data(32'h5555_0000);
        req_valid_i = 4'b0100;
        @(negedge clk);
        chk("mid_ready", 64'(req_ready_o), 64'b0100);
        @(posedge clk); #1 req_valid_i = '0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_assert", 64'(hs_req_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 64'(hs_req_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_gid", 64'(grant_id_o), 64'd0);
        chk("mid_rst_data", 64'(hs_data_o), 64'd0);
        chk("mid_rst_done", 64'(done_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_xfer(4'b1111, 0, 3, 32'h7700_0000);

`ifdef HS_ARB_TIMEOUT_EN
        begin
            int first_err, nerr, first_idle;
            first_err = -1; nerr = 0; first_idle = -1;
            @(posedge clk); #1 req_valid_i = 4'b0010;
            @(negedge clk);
            chk("to_ready", 64'(req_ready_o), 64'b0010);
            @(posedge clk); #1 req_valid_i = '0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (err_o) begin
                    nerr++;
                    if (first_err < 0) first_err = k;
                end
                if (!busy_o && first_idle < 0) first_idle = k;
                if (k == 16) chk("to_req_low", 64'(hs_req_o), 64'd0);
                @(posedge clk);
            end
            chk("to_first_err", 64'(first_err), 64'(16));
            chk("to_err_count", 64'(nerr), 64'd1);
            chk("to_idle", 64'(first_idle), 64'(31));
        end
`else
        begin
            int bad_req, bad_err, n;
            bad_req = 0; bad_err = 0; n = 0;
            @(posedge clk); #1;
            set_data(32'h9900_0000);
            req_valid_i = 4'b0010;
            @(negedge clk);
            while (req_ready_o == '0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("co_ready", 64'(req_ready_o), 64'b0010);
            sb_q.push_back('{1, 32'h9900_0001});
            @(posedge clk); #1 req_valid_i = '0;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (hs_req_o !== 1'b1) bad_req++;
                if (err_o !== 1'b0) bad_err++;
            end
            chk("co_req_held", 64'(bad_req), 64'd0);
            chk("co_err_zero", 64'(bad_err), 64'd0);
            @(posedge clk); #1 hs_ack_i = 1'b1;
            repeat (5) @(posedge clk);
            #1 hs_ack_i = 1'b0;
            repeat (6) @(posedge clk);
        end
`endif

        @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
